// File: rtl/iddmm_mul_arbiter.sv
// Shares one fully pipelined 128x128->256 multiplier between NUM_REQ requesters.
//
// The external multiplier has a fixed latency, no stall and no valid. This block
// does the following:
// - arbitrates issue slots round-robin;
// - registers the chosen operands into mul_x/mul_y;
// - carries the requester id down a tag pipe that runs alongside the multiplier;
// - steers each product into a per-requester first-word-fall-through FIFO.
//
// Credit-based admission: a requester can only fire while it holds a credit.
// A credit is a free FIFO slot that no in-flight product has already claimed.
// Because of this, a write into a full FIFO can never happen.
//
// Latency: a request that fires in cycle c is shown on rsp_valid in cycle
// c + MUL_LATENCY + 1.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    issue enable (no grants while low, in-flight work drains)
//   req_valid/req_ready   per-requester request handshake (req_ready is the grant)
//   req_x/req_y           packed operands, requester i at [i*128 +: 128]
//   rsp_valid/rsp_ready   per-requester result handshake
//   rsp_data              packed FIFO heads, requester i at [i*256 +: 256]
//   mul_x/mul_y           registered operands to the multiplier
//   mul_result            multiplier product, MUL_LATENCY-1 clocks after mul_x
//   idle                  nothing in flight, all FIFOs empty, no fire this cycle
module iddmm_mul_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MUL_LATENCY = 9,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_x,
    input  logic [NUM_REQ*128-1:0] req_y,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [NUM_REQ*256-1:0] rsp_data,
    output logic [127:0]           mul_x,
    output logic [127:0]           mul_y,
    input  logic [255:0]           mul_result,
    output logic                   idle
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CrW  = $clog2(FIFO_DEPTH + 1);

    logic [IdW-1:0]     rr_ptr_q;
    logic [127:0]       mul_x_q, mul_y_q;
    // Stage 0 is loaded together with mul_x_q. The last stage is aligned with mul_result.
    logic [MUL_LATENCY-1:0] tag_vld_q;
    logic [IdW-1:0]     tag_id_q [MUL_LATENCY];
    logic [CrW-1:0]     credit_q [NUM_REQ];
    logic [PtrW:0]      wptr_q [NUM_REQ];
    logic [PtrW:0]      rptr_q [NUM_REQ];
    logic [255:0]       mem_q [NUM_REQ][FIFO_DEPTH];

    logic [NUM_REQ-1:0] eligible, grant;
    logic [IdW-1:0]     gnt_id;
    logic               fire;
    logic [NUM_REQ-1:0] fifo_empty, fifo_full, fifo_wr, fifo_rd;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = en & req_valid[i] & (credit_q[i] != '0);
        end
    end

    // Round-robin: the first eligible requester at or after rr_ptr_q wins.
    always_comb begin
        logic [IdW:0] sum;
        logic         found;
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        sum    = '0;
        for (int unsigned o = 0; o < NUM_REQ; o++) begin
            sum = {1'b0, rr_ptr_q} + (IdW + 1)'(o);
            if (sum >= (IdW + 1)'(NUM_REQ)) begin
                sum = sum - (IdW + 1)'(NUM_REQ);
            end
            if (!found && eligible[sum[IdW-1:0]]) begin
                found                = 1'b1;
                grant[sum[IdW-1:0]]  = 1'b1;
                gnt_id               = sum[IdW-1:0];
            end
        end
    end

    assign fire      = |grant;
    assign req_ready = grant;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            mul_x_q   <= '0;
            mul_y_q   <= '0;
            tag_vld_q <= '0;
            for (int unsigned j = 0; j < MUL_LATENCY; j++) begin
                tag_id_q[j] <= '0;
            end
        end else begin
            if (fire) begin
                mul_x_q  <= req_x[int'(gnt_id)*128 +: 128];
                mul_y_q  <= req_y[int'(gnt_id)*128 +: 128];
                rr_ptr_q <= (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            tag_vld_q   <= {tag_vld_q[MUL_LATENCY-2:0], fire};
            tag_id_q[0] <= gnt_id;
            for (int unsigned j = 1; j < MUL_LATENCY; j++) begin
                tag_id_q[j] <= tag_id_q[j-1];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            fifo_empty[i] = (wptr_q[i] == rptr_q[i]);
            fifo_full[i]  = (wptr_q[i][PtrW] != rptr_q[i][PtrW]) &&
                            (wptr_q[i][PtrW-1:0] == rptr_q[i][PtrW-1:0]);
            fifo_wr[i]    = tag_vld_q[MUL_LATENCY-1] && (tag_id_q[MUL_LATENCY-1] == IdW'(i));
            fifo_rd[i]    = ~fifo_empty[i] & rsp_ready[i];
            rsp_valid[i]  = ~fifo_empty[i];
            rsp_data[i*256 +: 256] = fifo_empty[i] ? '0 : mem_q[i][rptr_q[i][PtrW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wptr_q[i]   <= '0;
                rptr_q[i]   <= '0;
                credit_q[i] <= CrW'(FIFO_DEPTH);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (fifo_wr[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
                if (fifo_rd[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
                if (grant[i] && !fifo_rd[i]) begin
                    credit_q[i] <= credit_q[i] - 1'b1;
                end else if (!grant[i] && fifo_rd[i]) begin
                    credit_q[i] <= credit_q[i] + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (fifo_wr[i]) mem_q[i][wptr_q[i][PtrW-1:0]] <= mul_result;
        end
    end

    assign idle = ~|tag_vld_q & (&fifo_empty) & ~fire;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
        a_no_full_write: assert property (@(posedge clk) disable iff (!rst_n)
            !(fifo_wr[g] && fifo_full[g] && !fifo_rd[g]));
    end

endmodule

// File: tb/tb_iddmm_mul_arbiter.sv
// Randomised and directed bench for iddmm_mul_arbiter.
// It contains an external multiplier model with MUL_LATENCY-1 product stages after the operand register.
// A negedge monitor checks each cycle against a queue-based scoreboard:
// - grants are compared with a round-robin / credit reference;
// - rsp_valid timing and rsp_data values are compared with the scoreboard;
// - idle is compared with the scoreboard state.
module tb_iddmm_mul_arbiter;
    localparam int NR  = 4;
    localparam int ML  = 9;
    localparam int FD  = 4;
    localparam int LAT = ML + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*128-1:0] req_x, req_y;
    logic [NR*256-1:0] rsp_data;
    logic [127:0]      mul_x, mul_y;
    logic [255:0]      mul_result;
    logic              idle;

    iddmm_mul_arbiter #(.NUM_REQ(NR), .MUL_LATENCY(ML), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_x(mul_x), .mul_y(mul_y), .mul_result(mul_result), .idle(idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [255:0] mpipe [ML-1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < ML - 1; j++) mpipe[j] <= '0;
        end else begin
            mpipe[0] <= {128'd0, mul_x} * {128'd0, mul_y};
            for (int j = 1; j < ML - 1; j++) mpipe[j] <= mpipe[j-1];
        end
    end
    assign mul_result = mpipe[ML-2];

    typedef struct {
        logic [255:0] prod;
        int           fcyc;
    } exp_t;

    exp_t exp_q [NR][$];
    int   rr_model;
    int   gcnt [NR];
    int   pcnt [NR];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    endtask

    // Scoreboard monitor.
    logic [NR-1:0] m_gnt;
    logic          m_vld;
    int            m_k, m_total;
    exp_t          m_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) exp_q[i].delete();
            rr_model = 0;
        end else begin
            m_gnt = '0;
            for (int o = 0; o < NR; o++) begin
                m_k = (rr_model + o) % NR;
                if (m_gnt == '0 && en && req_valid[m_k] && exp_q[m_k].size() < FD)
                    m_gnt[m_k] = 1'b1;
            end
            chk("grant", 256'(req_ready), 256'(m_gnt));
            m_total = 0;
            for (int i = 0; i < NR; i++) m_total += exp_q[i].size();
            chk("idle", 256'(idle), 256'(m_total == 0 && m_gnt == '0));
            for (int i = 0; i < NR; i++) begin
                m_vld = 1'b0;
                if (exp_q[i].size() > 0) m_vld = (cyc >= exp_q[i][0].fcyc + LAT);
                chk($sformatf("rsp_valid[%0d]", i), 256'(rsp_valid[i]), 256'(m_vld));
                if (m_vld && rsp_valid[i] && rsp_ready[i]) begin
                    chk($sformatf("rsp_data[%0d]", i), rsp_data[i*256 +: 256],
                        exp_q[i][0].prod);
                    void'(exp_q[i].pop_front());
                    pcnt[i]++;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (m_gnt[i]) begin
                    m_e.prod = {128'd0, req_x[i*128 +: 128]} * {128'd0, req_y[i*128 +: 128]};
                    m_e.fcyc = cyc;
                    exp_q[i].push_back(m_e);
                    rr_model = (i + 1) % NR;
                    gcnt[i]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < NR; i++) begin
            gcnt[i] = 0;
            pcnt[i] = 0;
        end
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        rsp_ready = '1;
        n = 0;
        while (!idle && n < 100) begin
            step();
            n++;
        end
        @(negedge clk);
        chk("drain_idle", 256'(idle), 256'(1));
        step();
    endtask

    task automatic set_op(input int id, input logic [127:0] x, input logic [127:0] y);
        req_x[id*128 +: 128] = x;
        req_y[id*128 +: 128] = y;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 7) == 0) set_op(i, '1, '1);
            else set_op(i, {$urandom, $urandom, $urandom, $urandom},
                        {$urandom, $urandom, $urandom, $urandom});
        end
    endtask

    int           f, n;
    logic [127:0] big;

    initial begin
        rst_n = 1'b0; en = 1'b0; req_valid = '0; rsp_ready = '0; req_x = '0; req_y = '0;
        clr_cnt();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mul_x", 256'(mul_x), 256'(0));
        chk("rst_mul_y", 256'(mul_y), 256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_rsp_data", rsp_data[255:0], 256'(0));
        chk("rst_idle", 256'(idle), 256'(1));
        rst_n = 1'b1;
        step();

        // Single request: requester 1, 3*5.
        en = 1'b1; rsp_ready = '1;
        set_op(1, 128'd3, 128'd5); req_valid = 4'b0010;
        @(negedge clk);
        f = cyc;
        chk("single_grant", 256'(req_ready), 256'(4'b0010));
        step();
        req_valid = '0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[1] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("single_latency", 256'(cyc - f), 256'(LAT));
        chk("single_data", rsp_data[256 +: 256], 256'(15));
        @(negedge clk);
        chk("single_idle_back", 256'(idle), 256'(1));
        step();

        // Round-robin with all requesters valid.
        req_valid = '1;
        big = '0; big[127] = 1'b1;
        set_op(0, big, 128'd2);
        step();
        for (int c = 0; c < 40; c++) begin
            rand_ops();
            step();
        end
        drain();

        // Backpressure on requester 2.
        clr_cnt();
        req_valid = '1; rsp_ready = 4'b1011;
        for (int c = 0; c < 40; c++) begin
            rand_ops();
            step();
        end
        chk("bp_grants2", 256'(gcnt[2]), 256'(4));
        chk("bp_others", 256'(gcnt[0] > 0 && gcnt[1] > 0 && gcnt[3] > 0), 256'(1));
        gcnt[2] = 0;
        rsp_ready = 4'b1111;
        step();
        rsp_ready = 4'b1011;
        repeat (20) step();
        chk("bp_one_more", 256'(gcnt[2]), 256'(1));
        drain();

        // Ordering on requester 3 with toggling rsp_ready.
        clr_cnt();
        for (int k = 1; k <= 6; k++) begin
            set_op(3, 128'(k), 128'd7);
            req_valid = 4'b1000;
            n = 0;
            @(negedge clk);
            while (!req_ready[3] && n < 40) begin
                step();
                rsp_ready[3] = ~rsp_ready[3];
                @(negedge clk);
                n++;
            end
            chk("order_issue", 256'(req_ready[3]), 256'(1));
            step();
            rsp_ready[3] = ~rsp_ready[3];
            req_valid = '0;
        end
        for (int c = 0; c < 40; c++) begin
            rsp_ready[3] = ~rsp_ready[3];
            step();
        end
        chk("order_count", 256'(pcnt[3]), 256'(6));
        drain();

        // en low with three requests in flight.
        clr_cnt();
        req_valid = '1; en = 1'b1;
        rand_ops();
        repeat (3) step();
        en = 1'b0;
        repeat (25) step();
        chk("en_fires", 256'(gcnt[0] + gcnt[1] + gcnt[2] + gcnt[3]), 256'(3));
        chk("en_delivered", 256'(pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]), 256'(3));
        @(negedge clk);
        chk("en_idle", 256'(idle), 256'(1));
        step();
        en = 1'b1;
        step();
        drain();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid = NR'($urandom);
            rsp_ready = NR'($urandom);
            en = ($urandom_range(0, 7) != 0);
            rand_ops();
            step();
        end
        en = 1'b1;
        drain();

        // Reset with five products in flight.
        rsp_ready = '0; req_valid = '1;
        rand_ops();
        repeat (5) step();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("mid_rst_idle", 256'(idle), 256'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (20) step();
        clr_cnt();
        req_valid = 4'b0001;
        repeat (14) step();
        chk("mid_rst_credit", 256'(gcnt[0]), 256'(FD));
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
